// File: rtl/dct_pkg.sv
// Shared types and elaboration-time helpers for the parametrised 1-D DCT engine:
// FSM state encoding, accumulator width and the cosine coefficient generator.
package dct_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_MAC   = 3'd3,
    ST_WRITE = 3'd4
  } dct_state_e;

  // Accumulator must hold N products of a sample and a coefficient without overflow.
  function automatic int acc_width(input int data_w, input int coef_frac, input int n);
    return data_w + coef_frac + 2 + $clog2(n);
  endfunction

  // cos(k*pi/32) scaled by 2^30 for k = 0..16 (first quadrant, covers N up to 16).
  function automatic longint cos_q30(input int k);
    case (k)
      0:       return 64'sd1073741824;
      1:       return 64'sd1068571464;
      2:       return 64'sd1053110176;
      3:       return 64'sd1027506862;
      4:       return 64'sd992008094;
      5:       return 64'sd946955747;
      6:       return 64'sd892783698;
      7:       return 64'sd830013654;
      8:       return 64'sd759250125;
      9:       return 64'sd681174602;
      10:      return 64'sd596538995;
      11:      return 64'sd506158392;
      12:      return 64'sd410903207;
      13:      return 64'sd311690799;
      14:      return 64'sd209476638;
      15:      return 64'sd105245103;
      default: return 64'sd0;
    endcase
  endfunction

  // Orthonormal DCT-II coefficient c(u,x) rounded to coef_frac fractional bits.
  // The angle (2x+1)*u*pi/(2n) is folded onto the quarter-wave table; the
  // normalisation sqrt(1/n) or sqrt(2/n) is 2^(-h/2), split into a 1/sqrt(2)
  // factor for odd h plus a plain shift.
  function automatic int dct_coef(input int n, input int coef_frac, input int u, input int x);
    int     m;
    int     k;
    int     h;
    int     sh;
    longint v;
    longint base;
    longint prod;
    m = ((2 * x + 1) * u) % (4 * n);
    k = m * (16 / n);
    if (k > 32) k = 64 - k;
    if (k <= 16) v = cos_q30(k);
    else         v = -cos_q30(32 - k);
    h    = (u == 0) ? $clog2(n) : $clog2(n) - 1;
    base = (h % 2 == 1) ? 64'sd759250125 : 64'sd1073741824;
    prod = v * base;
    sh   = 60 + (h / 2) - coef_frac;
    return int'((prod + (longint'(1) <<< (sh - 1))) >>> sh);
  endfunction

endpackage

// File: rtl/dct_coef_rom.sv
// Combinational cosine ROM: returns c(u,x), or the transpose c(x,u) in inverse mode.
// Contents are computed at elaboration from the package generator.
module dct_coef_rom
  import dct_pkg::*;
#(
  parameter int N         = 8,
  parameter int COEF_FRAC = 14,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic [IDX_W-1:0]           i_u,
  input  logic [IDX_W-1:0]           i_x,
  input  logic                       i_inv,
  output logic signed [COEF_FRAC+1:0] o_coef
);

  localparam int CW = COEF_FRAC + 2;

  logic signed [CW-1:0]  w_rom [N*N];
  logic [2*IDX_W-1:0]    w_idx;

  for (genvar gu = 0; gu < N; gu++) begin : g_u
    for (genvar gx = 0; gx < N; gx++) begin : g_x
      localparam int CV = dct_coef(N, COEF_FRAC, gu, gx);
      assign w_rom[gu*N+gx] = CW'(CV);
    end
  end

  // N is a power of two, so row-major index is a plain concatenation.
  assign w_idx  = i_inv ? {i_x, i_u} : {i_u, i_x};
  assign o_coef = w_rom[w_idx];

endmodule

// File: rtl/dct1d_gen.sv
// Parametrised 1-D DCT-II / inverse DCT-III engine on a shared single-port RAM.
// Reads N samples at rstart+k*stride, computes each output with a serial MAC
// against the cosine ROM and writes it at wstart+u*stride.
// Optional clamping of results (with sticky ovf) is enabled by DCT1D_GEN_SAT_EN;
// without it results wrap to DATA_W bits and ovf is tied low.
module dct1d_gen
  import dct_pkg::*;
#(
  parameter int N         = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int COEF_FRAC = 14,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              inv,
  input  logic [ADDR_W-1:0] rstart,
  input  logic [ADDR_W-1:0] wstart,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic              wren,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] q,
  output logic              rdy,
  output logic              ovf
);

  localparam int IDX_W  = $clog2(N);
  localparam int CW     = COEF_FRAC + 2;
  localparam int ACC_W  = acc_width(DATA_W, COEF_FRAC, N);
  localparam int PROD_W = DATA_W + CW;
  localparam logic [IDX_W-1:0]        IDX_MAX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]        IDX_ONE  = IDX_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_HALF = ACC_W'(longint'(1) <<< (COEF_FRAC - 1));

  dct_state_e                r_state;
  dct_state_e                w_next;
  logic                      r_inv;
  logic [ADDR_W-1:0]         r_raddr;
  logic [ADDR_W-1:0]         r_waddr;
  logic [ADDR_W-1:0]         r_stride;
  logic [IDX_W-1:0]          r_k;
  logic [IDX_W-1:0]          r_x;
  logic [IDX_W-1:0]          r_u;
  logic signed [DATA_W-1:0]  r_s [N];
  logic signed [ACC_W-1:0]   r_acc;

  logic                      w_cap_en;
  logic [IDX_W-1:0]          w_cap_idx;
  logic signed [DATA_W-1:0]  w_samp;
  logic signed [CW-1:0]      w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic [DATA_W-1:0]         w_data;

  dct_coef_rom #(
    .N         (N),
    .COEF_FRAC (COEF_FRAC),
    .IDX_W     (IDX_W)
  ) u_rom (
    .i_u    (r_u),
    .i_x    (r_x),
    .i_inv  (r_inv),
    .o_coef (w_coef)
  );

  // State register; async reset aborts any operation immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and RAM-side outputs; wren is only ever high in WRITE.
  always_comb begin
    w_next = r_state;
    rdy    = 1'b0;
    wren   = 1'b0;
    addr   = '0;
    data   = '0;
    case (r_state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) w_next = ST_READ;
      end
      ST_READ: begin
        addr = r_raddr;
        if (r_k == IDX_MAX) w_next = (RD_LAT != 0) ? ST_DRAIN : ST_MAC;
      end
      ST_DRAIN: w_next = ST_MAC;
      ST_MAC: begin
        if (r_x == IDX_MAX) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        wren   = 1'b1;
        addr   = r_waddr;
        data   = w_data;
        w_next = (r_u == IDX_MAX) ? ST_IDLE : ST_MAC;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operation parameters, address generators and loop counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inv    <= 1'b0;
      r_raddr  <= '0;
      r_waddr  <= '0;
      r_stride <= '0;
      r_k      <= '0;
      r_x      <= '0;
      r_u      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_inv    <= inv;
            r_raddr  <= rstart;
            r_waddr  <= wstart;
            r_stride <= stride;
            r_k      <= '0;
            r_x      <= '0;
            r_u      <= '0;
          end
        end
        ST_READ: begin
          r_raddr <= r_raddr + r_stride;
          r_k     <= r_k + IDX_ONE;
        end
        ST_MAC:   r_x <= r_x + IDX_ONE;
        ST_WRITE: begin
          r_waddr <= r_waddr + r_stride;
          r_u     <= r_u + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Which buffer slot the current q belongs to, given the RAM read latency.
  always_comb begin
    w_cap_en  = 1'b0;
    w_cap_idx = r_k;
    if (RD_LAT == 0) begin
      w_cap_en  = (r_state == ST_READ);
    end else if (r_state == ST_READ) begin
      w_cap_en  = (r_k != '0);
      w_cap_idx = r_k - IDX_ONE;
    end else if (r_state == ST_DRAIN) begin
      w_cap_en  = 1'b1;
      w_cap_idx = IDX_MAX;
    end
  end

  // Sample buffer; fully loaded before the first write, so in-place is safe.
  always_ff @(posedge clk) begin
    if (w_cap_en) r_s[w_cap_idx] <= q;
  end

  assign w_samp     = r_s[r_x];
  assign w_prod     = w_samp * w_coef;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Serial MAC; the first term of each output replaces the previous sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_acc <= '0;
    else if (r_state == ST_MAC) r_acc <= ((r_x == '0) ? '0 : r_acc) + w_prod_ext;
  end

  // Round half up before dropping the fractional bits.
  assign w_sum = r_acc + ACC_HALF;

`ifdef DCT1D_GEN_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(longint'(1) <<< (DATA_W - 1)));
  localparam logic [DATA_W-1:0]       D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] w_res;
  logic                    w_clip;
  logic                    r_ovf;

  assign w_res = w_sum >>> COEF_FRAC;

  // Clamp out-of-range results to the nearest representable bound.
  always_comb begin
    w_data = w_res[DATA_W-1:0];
    w_clip = 1'b0;
    if (w_res > SAT_MAX) begin
      w_data = D_MAX;
      w_clip = 1'b1;
    end else if (w_res < SAT_MIN) begin
      w_data = D_MIN;
      w_clip = 1'b1;
    end
  end

  // Sticky overflow, cleared when the next operation is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_ovf <= 1'b0;
    else if (r_state == ST_IDLE && en)      r_ovf <= 1'b0;
    else if (r_state == ST_WRITE && w_clip) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`else
  logic w_unused;

  assign w_data   = w_sum[COEF_FRAC +: DATA_W];
  assign w_unused = ^{w_sum[COEF_FRAC-1:0], w_sum[ACC_W-1:COEF_FRAC+DATA_W]};
  assign ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_dct1d_gen.sv
// Directed testbench for dct1d_gen with default parameters (N=8, RD_LAT=1).
module tb_dct1d_gen;

  localparam int EXP_BUSY = 81;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        en      = 1'b0;
  logic        inv     = 1'b0;
  logic [5:0]  rstart  = '0;
  logic [5:0]  wstart  = '0;
  logic [5:0]  stride  = '0;
  logic [5:0]  addr;
  logic        wren;
  logic [15:0] data;
  logic [15:0] q;
  logic        rdy;
  logic        ovf;

  logic [15:0] ram [64];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_wa = '0;
  logic [15:0] tb_wd = '0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy;
  logic [5:0]  log_addr [256];
  logic        log_wren [256];

  dct1d_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .inv     (inv),
    .rstart  (rstart),
    .wstart  (wstart),
    .stride  (stride),
    .addr    (addr),
    .wren    (wren),
    .data    (data),
    .q       (q),
    .rdy     (rdy),
    .ovf     (ovf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-port RAM, one cycle read latency; bench preload port used only while idle
  always @(posedge clk) begin
    if (wren)       ram[addr]  <= data;
    else if (tb_we) ram[tb_wa] <= tb_wd;
    q <= ram[addr];
  end

  task automatic ram_wr(input logic [5:0] a, input logic [15:0] v);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Starts one operation and logs addr/wren for each busy cycle (log index = cycle-1).
  task automatic run_op(input logic i_inv, input logic [5:0] rs, input logic [5:0] ws,
                        input logic [5:0] st, input int pulse_at);
    inv    = i_inv;
    rstart = rs;
    wstart = ws;
    stride = st;
    en     = 1'b1;
    @(negedge clk);
    en   = 1'b0;
    busy = 0;
    while (rdy === 1'b0 && busy < 200) begin
      log_addr[busy] = addr;
      log_wren[busy] = wren;
      busy++;
      if (busy == pulse_at) begin
        en     = 1'b1;
        inv    = ~i_inv;
        rstart = rs + 6'h10;
      end else begin
        en     = 1'b0;
        inv    = i_inv;
        rstart = rs;
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rdy !== 1'b1)   begin n_bad++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    n_cmp++; if (wren !== 1'b0)  begin n_bad++; $display("FAIL reset_wren: got %b expected 0", wren); end
    n_cmp++; if (addr !== 6'h00) begin n_bad++; $display("FAIL reset_addr: got %h expected 00", addr); end
    n_cmp++; if (data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_cmp++; if (ovf !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dc();
    for (int k = 0; k < 8; k++) ram_wr(6'(k), 16'h0010);
    run_op(1'b0, 6'h00, 6'h00, 6'h01, -1);
    n_cmp++; if (busy !== EXP_BUSY) begin n_bad++; $display("FAIL dc_busy: got %0d expected %0d", busy, EXP_BUSY); end
    n_cmp++; if (ram[0] !== 16'h002D) begin n_bad++; $display("FAIL dc_ram0: got %h expected 002d", ram[0]); end
    for (int k = 1; k < 8; k++) begin
      n_cmp++;
      if (ram[k] !== 16'h0000) begin n_bad++; $display("FAIL dc_ram[%0d]: got %h expected 0000", k, ram[k]); end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] exp_v [8];
    exp_v = '{16'd91, 16'd126, 16'd118, 16'd106, 16'd91, 16'd71, 16'd49, 16'd25};
    ram_wr(6'h00, 16'h0100);
    for (int k = 1; k < 8; k++) ram_wr(6'(k), 16'h0000);
    run_op(1'b0, 6'h00, 6'h00, 6'h01, -1);
    for (int u = 0; u < 8; u++) begin
      n_cmp++;
      if (ram[u] !== exp_v[u]) begin n_bad++; $display("FAIL impulse_ram[%0d]: got %h expected %h", u, ram[u], exp_v[u]); end
    end
  endtask

  task automatic test_round_trip();
    int vec [8];
    int got;
    int d;
    vec = '{100, -200, 37, 255, -256, 0, -17, 64};
    for (int k = 0; k < 8; k++) ram_wr(6'(k), 16'(vec[k]));
    run_op(1'b0, 6'h00, 6'h10, 6'h01, -1);
    run_op(1'b1, 6'h10, 6'h20, 6'h01, -1);
    for (int k = 0; k < 8; k++) begin
      got = int'($signed(ram[6'h20 + 6'(k)]));
      d   = got - vec[k];
      n_cmp++;
      if (d > 1 || d < -1) begin n_bad++; $display("FAIL round_trip[%0d]: got %0d expected %0d+/-1", k, got, vec[k]); end
    end
  endtask

  task automatic test_column_wrap();
    logic [5:0] e;
    for (int k = 0; k < 8; k++) ram_wr(6'h38 + 6'(8 * k), 16'h0010);
    run_op(1'b0, 6'h38, 6'h39, 6'h08, -1);
    n_cmp++; if (busy !== EXP_BUSY) begin n_bad++; $display("FAIL col_busy: got %0d expected %0d", busy, EXP_BUSY); end
    for (int k = 0; k < 8; k++) begin
      e = 6'h38 + 6'(8 * k);
      n_cmp++;
      if (log_addr[k] !== e) begin n_bad++; $display("FAIL col_raddr[%0d]: got %h expected %h", k, log_addr[k], e); end
    end
    for (int k = 0; k < 9; k++) begin
      n_cmp++;
      if (log_wren[k] !== 1'b0) begin n_bad++; $display("FAIL col_read_wren[%0d]: got %b expected 0", k, log_wren[k]); end
    end
    for (int u = 0; u < 8; u++) begin
      e = 6'h39 + 6'(8 * u);
      n_cmp++;
      if (log_wren[17 + 9 * u] !== 1'b1 || log_addr[17 + 9 * u] !== e) begin
        n_bad++;
        $display("FAIL col_write[%0d]: got wren=%b addr=%h expected wren=1 addr=%h",
                 u, log_wren[17 + 9 * u], log_addr[17 + 9 * u], e);
      end
    end
    n_cmp++; if (ram[6'h39] !== 16'h002D) begin n_bad++; $display("FAIL col_ram39: got %h expected 002d", ram[6'h39]); end
  endtask

  task automatic test_en_ignored();
    for (int k = 0; k < 8; k++) ram_wr(6'(k), 16'h0010);
    run_op(1'b0, 6'h00, 6'h08, 6'h01, 10);
    n_cmp++; if (busy !== EXP_BUSY) begin n_bad++; $display("FAIL enign_busy: got %0d expected %0d", busy, EXP_BUSY); end
    n_cmp++; if (ram[8] !== 16'h002D) begin n_bad++; $display("FAIL enign_ram8: got %h expected 002d", ram[8]); end
    for (int k = 9; k < 16; k++) begin
      n_cmp++;
      if (ram[k] !== 16'h0000) begin n_bad++; $display("FAIL enign_ram[%0d]: got %h expected 0000", k, ram[k]); end
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    for (int k = 0; k < 8; k++) ram_wr(6'(k), 16'h0010);
    for (int k = 0; k < 8; k++) ram_wr(6'h28 + 6'(k), 16'h5555);
    inv    = 1'b0;
    rstart = 6'h00;
    wstart = 6'h28;
    stride = 6'h01;
    en     = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    cyc = 1;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL abort_busy30: got rdy=%b expected 0", rdy); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (wren !== 1'b0) begin n_bad++; $display("FAIL abort_wren: got %b expected 0", wren); end
    n_cmp++; if (rdy !== 1'b1)  begin n_bad++; $display("FAIL abort_rdy: got %b expected 1", rdy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if (ram[6'h28] !== 16'h002D) begin n_bad++; $display("FAIL abort_ram28: got %h expected 002d", ram[6'h28]); end
    n_cmp++; if (ram[6'h29] !== 16'h0000) begin n_bad++; $display("FAIL abort_ram29: got %h expected 0000", ram[6'h29]); end
    for (int k = 2; k < 8; k++) begin
      n_cmp++;
      if (ram[6'h28 + 6'(k)] !== 16'h5555) begin
        n_bad++;
        $display("FAIL abort_nowrite[%0d]: got %h expected 5555", k, ram[6'h28 + 6'(k)]);
      end
    end
  endtask

  task automatic test_after_reset();
    run_op(1'b0, 6'h00, 6'h28, 6'h01, -1);
    n_cmp++; if (busy !== EXP_BUSY) begin n_bad++; $display("FAIL post_busy: got %0d expected %0d", busy, EXP_BUSY); end
    n_cmp++; if (ram[6'h28] !== 16'h002D) begin n_bad++; $display("FAIL post_ram28: got %h expected 002d", ram[6'h28]); end
    n_cmp++; if (ram[6'h2A] !== 16'h0000) begin n_bad++; $display("FAIL post_ram2a: got %h expected 0000", ram[6'h2A]); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_r0;
    logic        exp_ovf;
`ifdef DCT1D_GEN_SAT_EN
    exp_r0  = 16'h7FFF;
    exp_ovf = 1'b1;
`else
    exp_r0  = 16'h6A0D;
    exp_ovf = 1'b0;
`endif
    for (int k = 0; k < 8; k++) ram_wr(6'(k), 16'h7FFF);
    run_op(1'b0, 6'h00, 6'h00, 6'h01, -1);
    n_cmp++; if (ram[0] !== exp_r0) begin n_bad++; $display("FAIL sat_ram0: got %h expected %h", ram[0], exp_r0); end
    n_cmp++; if (ovf !== exp_ovf)   begin n_bad++; $display("FAIL sat_ovf: got %b expected %b", ovf, exp_ovf); end
    for (int k = 0; k < 8; k++) ram_wr(6'(k), 16'h0010);
    run_op(1'b0, 6'h00, 6'h00, 6'h01, -1);
    n_cmp++; if (ovf !== 1'b0)        begin n_bad++; $display("FAIL sat_ovf_clear: got %b expected 0", ovf); end
    n_cmp++; if (ram[0] !== 16'h002D) begin n_bad++; $display("FAIL sat_dc_ram0: got %h expected 002d", ram[0]); end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_round_trip();
    test_column_wrap();
    test_en_ignored();
    test_reset_abort();
    test_after_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct1d_gen.md
Name: dct1d_gen

Overview:
Parametrised 1-D DCT-II / inverse DCT-III engine, successor to the fixed 8-point forward dct1d. It reads N signed samples from shared single-port RAM at programmable start and stride, then computes each coefficient with a serial MAC against a cosine ROM and writes the results back in place or elsewhere. Forward or inverse mode is selectable per operation, and RAM read latency is selectable. The MPEG2 2-D DCT controller calls it twice: rows with stride 1, then columns with stride N.

Parameters:
- N, 8: transform length; power of two, 2..16.
- DATA_W, 16: sample and RAM word width, signed two's complement.
- ADDR_W, 6: RAM address width; address arithmetic wraps mod 2^ADDR_W.
- COEF_FRAC, 14: fractional bits of ROM coefficients (signed, COEF_FRAC+2 bits wide).
- RD_LAT, 1: RAM read latency in cycles, 0 or 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- inv  in  1  0 = forward DCT-II, 1 = inverse DCT-III; latched at start
- rstart  in  ADDR_W  first read address; latched at start
- wstart  in  ADDR_W  first write address; latched at start
- stride  in  ADDR_W  address step for reads and writes; latched at start
- addr  out  ADDR_W  RAM address
- wren  out  1  RAM write enable
- data  out  DATA_W  RAM write data
- q  in  DATA_W  RAM read data
- rdy  out  1  idle and able to accept en
- ovf  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset values: rdy=1, wren=0, addr=0, data=0, ovf=0, state IDLE. Reset is asynchronous and legal mid-operation; it aborts the operation with no further writes.
- States:
  - IDLE: rdy=1. en=1 latches inv, rstart, wstart and stride, then goes to READ; rdy=0 from the next cycle.
  - READ: N cycles. addr = rstart + k*stride for k = 0..N-1. With RD_LAT=0, q is captured into buffer s[k] in the same cycle. With RD_LAT=1, q is captured into s[k-1] the following cycle.
  - DRAIN: present only when RD_LAT=1. One cycle to capture s[N-1]; wren=0.
  - MAC: N cycles per output u. acc += c(u,x)*s[x] for x = 0..N-1. Inverse mode uses c(x,u), the ROM transpose. acc is cleared at the start of each u.
  - WRITE: 1 cycle. wren=1, addr = wstart + u*stride, data = result(u). Then MAC for u+1, or IDLE after u = N-1.
- Busy time: rdy low for exactly N + RD_LAT + N*(N+1) cycles (81 for defaults). rdy rises the cycle after the last WRITE.
- Coefficients: c(u,x) = round(C(u)*cos((2x+1)*u*pi/(2N)) * 2^COEF_FRAC), with C(0) = sqrt(1/N) and C(u>0) = sqrt(2/N) (orthonormal).
- Arithmetic:
  - acc width = DATA_W + COEF_FRAC + 2 + log2(N), signed.
  - result = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half up.
  - Narrowing to DATA_W is governed by the Optional Feature.
- en while rdy=0 is ignored.
- Inputs are fully buffered before the first write, so wstart may equal rstart (in-place operation).
- A write cycle never overlaps a read cycle.
- Address overflow wraps silently, e.g. rstart=0x38, stride=8 reads 0x38, 0x00, 0x08, ...
- wren=0 in every state except WRITE.

Optional Feature:
- Macro: DCT1D_GEN_SAT_EN.
- Defined: a result outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] is clamped to the nearest bound and sets ovf. ovf stays set until reset or the next accepted en, which clears it.
- Undefined: results are truncated to the low DATA_W bits (wrap) and ovf is tied to 0.

Decomposition:
- Package dct_pkg:
  - coefficient ROM generation function, parametrised by N and COEF_FRAC and evaluated at elaboration;
  - state encoding typedef (IDLE, READ, DRAIN, MAC, WRITE);
  - accumulator width constant function.
- One sub-module, dct_coef_rom: combinational lookup of (u, x, inv) to signed coefficient.
- The datapath and FSM stay in dct1d_gen.

Test Plan (defaults: N=8, COEF_FRAC=14, RD_LAT=1):
- DC: all 8 inputs 0x0010, inv=0, rstart=wstart=0, stride=1 -> RAM[0]=0x002D, RAM[1..7]=0x0000; rdy low exactly 81 cycles.
- Impulse: RAM[0]=0x0100, RAM[1..7]=0, inv=0 -> RAM[0]=0x005B, RAM[1]=0x007E; all outputs match the golden model bit-exactly.
- Round trip: random inputs in [-256,255] forward to 0x10 with stride 1, then inverse from 0x10 back to 0x20 -> RAM[0x20+k] within +/-1 of the originals.
- Column and wrap: rstart=0x38, wstart=0x39, stride=8 -> read addresses 0x38, 0x00, 0x08, ..., 0x30; write addresses 0x39, 0x01, ..., 0x31; no wren during READ or DRAIN.
- Control:
  - en pulsed at busy cycle 10 -> ignored, and the operation result is unchanged;
  - reset_n low at busy cycle 30 -> wren=0 and rdy=1 immediately, no further writes;
  - a following operation completes correctly.
- Saturation: all inputs 0x7FFF, inv=0 -> RAM[0]=0x7FFF and ovf=1 with DCT1D_GEN_SAT_EN; RAM[0]=0x6A0D and ovf=0 without it.
